// File: rtl/mycpu_pkg.sv
// Shared CPU-wide constants: default datapath widths used by the fetch/decode blocks.
package mycpu_pkg;
  localparam int PC_W_DEF   = 32;
  localparam int INST_W_DEF = 32;
endpackage

// File: rtl/ifq_storage.sv
// Instruction queue entry array: one synchronous write port, one asynchronous read port.
module ifq_storage #(
  parameter int DEPTH = 4,
  parameter int ENT_W = 65
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ENT_W-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ENT_W-1:0]         rdata
);
  logic [ENT_W-1:0] mem [DEPTH];

  // Contents are never reset; occupancy tracking in the parent decides validity.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// IF->ID instruction queue with valid/ready handshakes, delay-slot tagging and single-cycle flush.
module if_id_queue
  import mycpu_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [PC_W-1:0]          if_pc,
  input  logic [INST_W-1:0]        if_inst,
  input  logic                     if_addr_error,
  output logic                     id_valid,
  input  logic                     id_ready,
  input  logic                     id_branch,
  output logic [PC_W-1:0]          id_pc,
  output logic [INST_W-1:0]        id_inst,
  output logic                     id_addr_error,
  output logic                     id_bd,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = PC_W + INST_W + 1;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             bd_flag;
  logic             full, enq, deq;
  logic [ENT_W-1:0] wr_ent, rd_ent;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign if_ready = !full && !flush && !reset;
  assign id_valid = (cnt != '0);
  assign enq      = if_valid && if_ready;
  assign deq      = id_valid && id_ready;
  assign wr_ent   = {if_addr_error, if_pc, if_inst};

  ifq_storage #(.DEPTH(DEPTH), .ENT_W(ENT_W)) u_storage (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (wr_ent),
    .raddr (rd_ptr),
    .rdata (rd_ent)
  );

  // Flush and reset share the same clearing and override any same-edge handshake.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      bd_flag <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) begin
        rd_ptr  <= rd_ptr + 1'b1;
        bd_flag <= id_branch;
      end
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head data is masked to zero while empty so stale array contents never leak to ID.
  assign id_inst       = id_valid ? rd_ent[INST_W-1:0]           : '0;
  assign id_pc         = id_valid ? rd_ent[INST_W +: PC_W]       : '0;
  assign id_addr_error = id_valid ? rd_ent[ENT_W-1]              : 1'b0;
  assign id_bd         = id_valid && bd_flag;
  assign count         = cnt;
endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue with DEPTH = 4.
module tb_if_id_queue;
  logic        clk = 1'b0;
  logic        reset, flush, if_valid, if_ready, if_addr_error;
  logic [31:0] if_pc, if_inst, id_pc, id_inst;
  logic        id_valid, id_ready, id_branch, id_addr_error, id_bd;
  logic [2:0]  count;
  int checks = 0;
  int failures = 0;

  if_id_queue #(.PC_W(32), .INST_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst), .if_addr_error(if_addr_error),
    .id_valid(id_valid), .id_ready(id_ready), .id_branch(id_branch),
    .id_pc(id_pc), .id_inst(id_inst), .id_addr_error(id_addr_error),
    .id_bd(id_bd), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = 32'hA000_0000 | pc;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_id_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_id_pc"}, id_pc, 32'd0);
    chk({tag, "_id_inst"}, id_inst, 32'd0);
    chk({tag, "_id_addr_error"}, 32'(id_addr_error), 32'd0);
    chk({tag, "_id_bd"}, 32'(id_bd), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0;
    if_addr_error = 1'b0; id_ready = 1'b0; id_branch = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_if_ready", 32'(if_ready), 32'd1);

    // Fill to full with ID stalled
    for (int i = 0; i < 4; i++) begin
      push(32'h100 + 32'(4 * i));
      tick();
    end
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_if_ready", 32'(if_ready), 32'd0);
    chk("fill_id_pc", id_pc, 32'h100);
    chk("fill_id_inst", id_inst, 32'hA000_0100);
    push(32'h110);
    tick();
    chk("full_reject_count", 32'(count), 32'd4);
    chk("full_reject_pc", id_pc, 32'h100);

    // Full with both sides active: only dequeue on the first edge
    id_ready = 1'b1;
    chk("full_deq_if_ready_pre", 32'(if_ready), 32'd0);
    tick();
    chk("full_deq_count", 32'(count), 32'd3);
    chk("full_deq_if_ready", 32'(if_ready), 32'd1);
    chk("full_deq_pc", id_pc, 32'h104);
    tick();
    chk("enq_deq_count", 32'(count), 32'd3);
    chk("enq_deq_pc", id_pc, 32'h108);
    if_valid = 1'b0;
    tick();
    chk("drain_pc0", id_pc, 32'h10C);
    tick();
    chk("drain_pc1", id_pc, 32'h110);
    chk("drain_inst1", id_inst, 32'hA000_0110);
    tick();
    chk("drain_empty_valid", 32'(id_valid), 32'd0);
    chk("drain_empty_pc", id_pc, 32'd0);
    chk("drain_empty_inst", id_inst, 32'd0);

    // Delay slot across an empty gap
    id_ready = 1'b0;
    push(32'h200);
    tick();
    if_valid = 1'b0;
    chk("br_head_pc", id_pc, 32'h200);
    chk("br_head_bd", 32'(id_bd), 32'd0);
    id_ready = 1'b1; id_branch = 1'b1;
    tick();
    id_ready = 1'b0; id_branch = 1'b0;
    chk("gap_valid", 32'(id_valid), 32'd0);
    chk("gap_bd", 32'(id_bd), 32'd0);
    tick(); tick();
    push(32'h204);
    tick();
    chk("slot_pc", id_pc, 32'h204);
    chk("slot_bd", 32'(id_bd), 32'd1);
    push(32'h208);
    tick();
    if_valid = 1'b0;
    chk("slot_hold_bd", 32'(id_bd), 32'd1);
    id_ready = 1'b1;
    tick();
    chk("after_slot_pc", id_pc, 32'h208);
    chk("after_slot_bd", 32'(id_bd), 32'd0);
    tick();
    id_ready = 1'b0;
    chk("after_slot_empty", 32'(count), 32'd0);

    // Streaming at occupancy 2, pointers wrap
    push(32'h300); tick();
    push(32'h304); tick();
    chk("stream_pre_count", 32'(count), 32'd2);
    id_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push(32'h308 + 32'(4 * k));
      tick();
      chk($sformatf("stream_count_%0d", k), 32'(count), 32'd2);
      chk($sformatf("stream_pc_%0d", k), id_pc, 32'h304 + 32'(4 * k));
    end

    // Build count 3 with bd_flag set, then flush
    id_branch = 1'b1;
    push(32'h330);
    tick();
    id_ready = 1'b0; id_branch = 1'b0;
    push(32'h334);
    tick();
    chk("preflush_count", 32'(count), 32'd3);
    chk("preflush_pc", id_pc, 32'h32C);
    chk("preflush_bd", 32'(id_bd), 32'd1);
    flush = 1'b1; id_ready = 1'b1; id_branch = 1'b1;
    push(32'h338);
    #1;
    chk("flush_if_ready", 32'(if_ready), 32'd0);
    tick();
    flush = 1'b0; id_ready = 1'b0; id_branch = 1'b0; if_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(id_valid), 32'd0);
    push(32'h400);
    tick();
    if_valid = 1'b0;
    chk("postflush_pc", id_pc, 32'h400);
    chk("postflush_bd", 32'(id_bd), 32'd0);
    chk("postflush_count", 32'(count), 32'd1);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;

    // Address error follows its entry
    push(32'h3); if_addr_error = 1'b1;
    tick();
    push(32'h8); if_addr_error = 1'b0;
    chk("aerr_head", 32'(id_addr_error), 32'd1);
    chk("aerr_pc", id_pc, 32'h3);
    tick();
    if_valid = 1'b0;
    chk("aerr_still_head", 32'(id_addr_error), 32'd1);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk("aerr_next_pc", id_pc, 32'h8);
    chk("aerr_next", 32'(id_addr_error), 32'd0);

    // Mid-stream reset
    push(32'h500);
    tick();
    if_valid = 1'b0;
    chk("prereset_count", 32'(count), 32'd2);
    reset = 1'b1;
    tick();
    chk_reset_vals("midrst");
    chk("midrst_if_ready", 32'(if_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_release_if_ready", 32'(if_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
